// File: rtl/mysys_ram_reader.sv
// Avalon-MM burst-less read master: fetches a contiguous block of 32-bit words from on-chip RAM
// and re-emits them as an Avalon-ST packet through a show-ahead FIFO.
module mysys_ram_reader #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned LEN_W      = 13,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  reads_left_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  st_idx_q;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [CNT_W:0]    in_flight;

  logic start_accept;
  logic credit_ok;
  logic rd_accept;
  logic rd_beat;
  logic fifo_empty;
  logic fifo_full;
  logic fifo_wr;
  logic st_pop;

  assign start_accept = (state_q == StIdle) && start;
  assign start_addr   = base_addr & ~ADDR_W'(3);

  // fifo_count + outstanding never grows while a read is stalled (beats move words from one to
  // the other, pops shrink it), so an issued m_read cannot lose its credit before acceptance.
  assign in_flight = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
  assign credit_ok = in_flight < {1'b0, DEPTH_CNT};

  assign m_read       = (state_q == StRead) && credit_ok;
  assign m_address    = addr_q;
  assign m_byteenable = 4'b1111;
  assign rd_accept    = m_read && !m_waitrequest;
  assign rd_beat      = m_readdatavalid && (outstanding_q != '0);

  assign fifo_empty = (fifo_count_q == '0);
  assign fifo_full  = (fifo_count_q == DEPTH_CNT);
  assign st_valid   = !fifo_empty;
  assign st_pop     = st_valid && st_ready;
  assign fifo_wr    = rd_beat && (!fifo_full || st_pop);
  assign st_data    = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign st_sop     = st_valid && (st_idx_q == '0);
  assign st_eop     = st_valid && (st_idx_q == len_q - LEN_W'(1));

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (word_count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (rd_accept && (reads_left_q == LEN_W'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (st_pop && st_eop) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_accept, rd_beat})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    case ({fifo_wr, st_pop})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      reads_left_q  <= '0;
      len_q         <= '0;
      st_idx_q      <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      if (start_accept) begin
        addr_q       <= start_addr;
        reads_left_q <= word_count;
        len_q        <= word_count;
        st_idx_q     <= '0;
      end else begin
        if (rd_accept) begin
          addr_q       <= addr_q + ADDR_W'(4);
          reads_left_q <= reads_left_q - LEN_W'(1);
        end
        if (st_pop) begin
          st_idx_q <= st_idx_q + LEN_W'(1);
        end
      end
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (st_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: st_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= m_readdata;
    end
  end

endmodule
